// File: rtl/waveform_sample_writer_if.sv
// ---------------------------------------------------------------------------
// waveform_sample_writer_if
// Groups the two sample-stream handshakes, the freeze control and the single
// RAM write port driven by waveform_sample_writer.
//   master : the sample writer (accepts samples, drives the RAM write port)
//   slave  : the environment (sample producers, RAM, display control)
// ---------------------------------------------------------------------------
interface waveform_sample_writer_if;

  // ECG sample stream
  logic        ecg_valid;
  logic [11:0] ecg_data;
  logic        ecg_ready;

  // EMG sample stream
  logic        emg_valid;
  logic [11:0] emg_data;
  logic        emg_ready;

  // Display hold
  logic        freeze;

  // Signal RAM write port
  logic        mem_wen;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;

  // End-of-sweep marker
  logic        sweep_done;

  modport master (
    input  ecg_valid, ecg_data, emg_valid, emg_data, freeze,
    output ecg_ready, emg_ready, mem_wen, mem_addr, mem_wdata, sweep_done
  );

  modport slave (
    output ecg_valid, ecg_data, emg_valid, emg_data, freeze,
    input  ecg_ready, emg_ready, mem_wen, mem_addr, mem_wdata, sweep_done
  );

endinterface : waveform_sample_writer_if

// File: rtl/waveform_sample_writer.sv
// ---------------------------------------------------------------------------
// waveform_sample_writer
// Decimates the ECG and EMG sample streams and writes the kept samples into
// two circular sweep windows of the shared signal RAM, one word per clock.
// After every complete ECG sweep the peak-to-peak amplitude of that sweep is
// written to the numeric-display word.
//
// Optional build macro WAVE_AVG_EN:
//   defined   - each group of DECIM accepted samples is replaced by its mean
//               (DECIM must be a power of two, division is a right shift)
//   undefined - keep-first decimation, no accumulators
// ---------------------------------------------------------------------------
module waveform_sample_writer #(
  parameter logic [11:0] ECG_BASE  = 12'h559,
  parameter logic [11:0] EMG_BASE  = 12'h6AD,
  parameter logic [11:0] STAT_ADDR = 12'd1704,
  parameter int          DEPTH     = 320,
  parameter int          DECIM     = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  waveform_sample_writer_if.master bus
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [4:0]    CNT_LAST = 5'(DECIM - 1);
`ifdef WAVE_AVG_EN
  localparam int            SHIFT    = $clog2(DECIM);
`endif

  typedef enum logic [1:0] {
    IDLE,
    WR_ECG,
    WR_EMG,
    WR_STAT
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          both_pick;

  // Per-channel accept path
  logic [4:0]    ecg_cnt;
  logic [4:0]    emg_cnt;
  logic [11:0]   ecg_hold;
  logic [11:0]   emg_hold;
  logic          ecg_full;
  logic          emg_full;
  logic          ecg_take;
  logic          emg_take;
  logic          ecg_pend;
  logic          emg_pend;

  // Write-side state
  logic [PW-1:0] ecg_ptr;
  logic [PW-1:0] emg_ptr;
  logic          stat_pending;
  logic [11:0]   min_q;
  logic [11:0]   max_q;
  logic [11:0]   ptp_q;
  logic          toggle_q;
  logic [11:0]   ecg_lo;
  logic [11:0]   ecg_hi;

  // A channel can take a new sample only while its holding register is empty.
  assign bus.ecg_ready = !ecg_full;
  assign bus.emg_ready = !emg_full;
  assign ecg_take      = bus.ecg_valid && !ecg_full;
  assign emg_take      = bus.emg_valid && !emg_full;

  // A register being written this cycle is no longer a candidate for the next
  // write even though its full flag only clears at the end of the cycle.
  assign ecg_pend = ecg_full && (state != WR_ECG);
  assign emg_pend = emg_full && (state != WR_EMG);

  // Running extremes including the sample about to be written.
  assign ecg_lo = (ecg_hold < min_q) ? ecg_hold : min_q;
  assign ecg_hi = (ecg_hold > max_q) ? ecg_hold : max_q;

`ifdef WAVE_AVG_EN
  logic [15:0] ecg_acc;
  logic [15:0] emg_acc;
  logic [15:0] ecg_sum;
  logic [15:0] emg_sum;

  assign ecg_sum = ecg_acc + {4'd0, bus.ecg_data};
  assign emg_sum = emg_acc + {4'd0, bus.emg_data};

  // ECG accept path: accumulate a group, load its mean on the last sample.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ecg_cnt  <= '0;
      ecg_acc  <= '0;
      ecg_hold <= '0;
      ecg_full <= 1'b0;
    end else begin
      if (state == WR_ECG) ecg_full <= 1'b0;
      if (ecg_take) ecg_cnt <= (ecg_cnt == CNT_LAST) ? '0 : ecg_cnt + 1'b1;
      if (bus.freeze) begin
        ecg_acc <= '0;
      end else if (ecg_take) begin
        if (ecg_cnt == CNT_LAST) begin
          ecg_hold <= 12'(ecg_sum >> SHIFT);
          ecg_full <= 1'b1;
          ecg_acc  <= '0;
        end else begin
          ecg_acc  <= ecg_sum;
        end
      end
    end
  end

  // EMG accept path: same grouping as ECG.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      emg_cnt  <= '0;
      emg_acc  <= '0;
      emg_hold <= '0;
      emg_full <= 1'b0;
    end else begin
      if (state == WR_EMG) emg_full <= 1'b0;
      if (emg_take) emg_cnt <= (emg_cnt == CNT_LAST) ? '0 : emg_cnt + 1'b1;
      if (bus.freeze) begin
        emg_acc <= '0;
      end else if (emg_take) begin
        if (emg_cnt == CNT_LAST) begin
          emg_hold <= 12'(emg_sum >> SHIFT);
          emg_full <= 1'b1;
          emg_acc  <= '0;
        end else begin
          emg_acc  <= emg_sum;
        end
      end
    end
  end
`else
  // ECG accept path: keep the first sample of each group, discard the rest.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ecg_cnt  <= '0;
      ecg_hold <= '0;
      ecg_full <= 1'b0;
    end else begin
      if (state == WR_ECG) ecg_full <= 1'b0;
      if (ecg_take) begin
        ecg_cnt <= (ecg_cnt == CNT_LAST) ? '0 : ecg_cnt + 1'b1;
        if ((ecg_cnt == '0) && !bus.freeze) begin
          ecg_hold <= bus.ecg_data;
          ecg_full <= 1'b1;
        end
      end
    end
  end

  // EMG accept path: same keep-first decimation as ECG.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      emg_cnt  <= '0;
      emg_hold <= '0;
      emg_full <= 1'b0;
    end else begin
      if (state == WR_EMG) emg_full <= 1'b0;
      if (emg_take) begin
        emg_cnt <= (emg_cnt == CNT_LAST) ? '0 : emg_cnt + 1'b1;
        if ((emg_cnt == '0) && !bus.freeze) begin
          emg_hold <= bus.emg_data;
          emg_full <= 1'b1;
        end
      end
    end
  end
`endif

  // Write FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Write arbitration: statistics first, then a lone full channel, then
  // alternate between channels when both are waiting.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = IDLE;
    both_pick  = 1'b0;
    if (stat_pending) begin
      next_state = WR_STAT;
    end else if (ecg_pend && emg_pend) begin
      both_pick  = 1'b1;
      next_state = toggle_q ? WR_EMG : WR_ECG;
    end else if (ecg_pend) begin
      next_state = WR_ECG;
    end else if (emg_pend) begin
      next_state = WR_EMG;
    end
  end

  // Write port, pointers and sweep statistics, all updated on entry to the
  // write state so the registered port is valid for exactly that cycle.
  // NOTE: the address/data registers and the holding registers are reset even
  // though they are datapath, so no stale word can reach the RAM after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.mem_wen    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.sweep_done <= 1'b0;
      ecg_ptr        <= '0;
      emg_ptr        <= '0;
      stat_pending   <= 1'b0;
      min_q          <= 12'hFFF;
      max_q          <= 12'h000;
      ptp_q          <= 12'h000;
      toggle_q       <= 1'b0;
    end else begin
      bus.mem_wen    <= (next_state != IDLE);
      bus.sweep_done <= 1'b0;
      if (both_pick) toggle_q <= ~toggle_q;
      unique case (next_state)
        WR_ECG: begin
          bus.mem_addr  <= ECG_BASE + 12'(ecg_ptr);
          bus.mem_wdata <= {20'd0, ecg_hold};
          if (ecg_ptr == PTR_LAST) begin
            ecg_ptr        <= '0;
            bus.sweep_done <= 1'b1;
            stat_pending   <= 1'b1;
            ptp_q          <= ecg_hi - ecg_lo;
            // Empty extremes so the first sample of the next sweep seeds both.
            min_q          <= 12'hFFF;
            max_q          <= 12'h000;
          end else begin
            ecg_ptr        <= ecg_ptr + 1'b1;
            min_q          <= ecg_lo;
            max_q          <= ecg_hi;
          end
        end
        WR_EMG: begin
          bus.mem_addr  <= EMG_BASE + 12'(emg_ptr);
          bus.mem_wdata <= {20'd0, emg_hold};
          emg_ptr       <= (emg_ptr == PTR_LAST) ? '0 : emg_ptr + 1'b1;
        end
        WR_STAT: begin
          bus.mem_addr  <= STAT_ADDR;
          bus.mem_wdata <= {20'd0, ptp_q};
          stat_pending  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule : waveform_sample_writer

// File: tb/tb_waveform_sample_writer.sv
// ---------------------------------------------------------------------------
// tb_waveform_sample_writer
// Directed scenarios followed by a randomized run. Expected RAM writes come
// from a sample-level model: every kept sample becomes one queued write to
// its window, and each completed ECG sweep queues one amplitude word.
// ---------------------------------------------------------------------------
module tb_waveform_sample_writer;

  localparam logic [11:0] ECG_BASE  = 12'h559;
  localparam logic [11:0] EMG_BASE  = 12'h6AD;
  localparam logic [11:0] STAT_ADDR = 12'd1704;
  localparam int          DEPTH     = 320;
  localparam int          MD        = 1;   // decimation of the modelled DUT

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        sweep;
  } wr_t;

  logic clock;
  logic reset;

  waveform_sample_writer_if b1 ();
  waveform_sample_writer_if b4 ();

  waveform_sample_writer #(.DECIM(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
  );

  waveform_sample_writer #(.DECIM(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (b4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int  n_vec;
  int  n_err;

  // Reference model state
  wr_t         ecg_q[$];
  wr_t         emg_q[$];
  wr_t         stat_q[$];
  wr_t         log_q[$];
  wr_t         log4_q[$];
  int          m_ecg_n;
  int          m_emg_n;
  int          m_ecg_ptr;
  int          m_emg_ptr;
  logic [11:0] m_min;
  logic [11:0] m_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ecg_q.delete();
    emg_q.delete();
    stat_q.delete();
    log_q.delete();
    log4_q.delete();
    m_ecg_n   = 0;
    m_emg_n   = 0;
    m_ecg_ptr = 0;
    m_emg_ptr = 0;
    m_min     = 12'hFFF;
    m_max     = 12'h000;
  endtask

  task automatic model_ecg(input logic [11:0] d, input logic frz);
    wr_t w;
    wr_t s;
    if ((m_ecg_n % MD) == 0 && !frz) begin
      w.addr  = ECG_BASE + 12'(m_ecg_ptr);
      w.data  = {20'd0, d};
      w.sweep = (m_ecg_ptr == DEPTH - 1);
      ecg_q.push_back(w);
      if (d < m_min) m_min = d;
      if (d > m_max) m_max = d;
      if (w.sweep) begin
        s.addr  = STAT_ADDR;
        s.data  = {20'd0, m_max - m_min};
        s.sweep = 1'b0;
        stat_q.push_back(s);
        m_min = 12'hFFF;
        m_max = 12'h000;
      end
      m_ecg_ptr = (m_ecg_ptr + 1) % DEPTH;
    end
    m_ecg_n = (m_ecg_n + 1) % MD;
  endtask

  task automatic model_emg(input logic [11:0] d, input logic frz);
    wr_t w;
    if ((m_emg_n % MD) == 0 && !frz) begin
      w.addr  = EMG_BASE + 12'(m_emg_ptr);
      w.data  = {20'd0, d};
      w.sweep = 1'b0;
      emg_q.push_back(w);
      m_emg_ptr = (m_emg_ptr + 1) % DEPTH;
    end
    m_emg_n = (m_emg_n + 1) % MD;
  endtask

  // One clock of dut1: feed accepted samples to the model, then check any
  // write that appears against the oldest expected write of its window.
  task automatic tick();
    logic        ae;
    logic        am;
    logic        fz;
    logic [11:0] de;
    logic [11:0] dm;
    logic        have;
    wr_t         o;
    wr_t         e;
    ae = b1.ecg_valid && b1.ecg_ready;
    am = b1.emg_valid && b1.emg_ready;
    fz = b1.freeze;
    de = b1.ecg_data;
    dm = b1.emg_data;
    @(posedge clock);
    if (ae) model_ecg(de, fz);
    if (am) model_emg(dm, fz);
    #1;
    if (b1.mem_wen) begin
      o.addr  = b1.mem_addr;
      o.data  = b1.mem_wdata;
      o.sweep = b1.sweep_done;
      log_q.push_back(o);
      have = 1'b0;
      e    = o;
      if (o.addr == STAT_ADDR) begin
        have = (stat_q.size() > 0);
        if (have) e = stat_q.pop_front();
      end else if (int'(o.addr) >= int'(ECG_BASE) && int'(o.addr) < int'(ECG_BASE) + DEPTH) begin
        have = (ecg_q.size() > 0);
        if (have) e = ecg_q.pop_front();
      end else begin
        have = (emg_q.size() > 0);
        if (have) e = emg_q.pop_front();
      end
      check("write_expected", 32'(have), 32'd1);
      if (have) begin
        check("wr_addr",  32'(o.addr),  32'(e.addr));
        check("wr_data",  o.data,       e.data);
        check("wr_sweep", 32'(o.sweep), 32'(e.sweep));
      end
    end else begin
      check("sweep_idle", 32'(b1.sweep_done), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_ecg(input logic [11:0] d);
    logic done;
    done = 1'b0;
    b1.ecg_valid = 1'b1;
    b1.ecg_data  = d;
    for (int k = 0; k < 16 && !done; k++) begin
      done = b1.ecg_ready;
      tick();
    end
    b1.ecg_valid = 1'b0;
    check("ecg_accept", 32'(done), 32'd1);
  endtask

  task automatic tick4();
    wr_t o;
    @(posedge clock);
    #1;
    if (b4.mem_wen) begin
      o.addr  = b4.mem_addr;
      o.data  = b4.mem_wdata;
      o.sweep = b4.sweep_done;
      log4_q.push_back(o);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    b1.ecg_valid = 1'b0;
    b1.emg_valid = 1'b0;
    b1.ecg_data  = '0;
    b1.emg_data  = '0;
    b1.freeze    = 1'b0;
    b4.ecg_valid = 1'b0;
    b4.emg_valid = 1'b0;
    b4.ecg_data  = '0;
    b4.emg_data  = '0;
    b4.freeze    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        done;
    n_vec = 0;
    n_err = 0;

    // ---- Reset state ----
    do_reset();
    check("rst_ecg_ready",  32'(b1.ecg_ready),  32'd1);
    check("rst_emg_ready",  32'(b1.emg_ready),  32'd1);
    check("rst_mem_wen",    32'(b1.mem_wen),    32'd0);
    check("rst_mem_addr",   32'(b1.mem_addr),   32'd0);
    check("rst_mem_wdata",  b1.mem_wdata,       32'd0);
    check("rst_sweep_done", 32'(b1.sweep_done), 32'd0);

    // ---- Single ECG sample: write one cycle after the accept edge ----
    send_ecg(12'h3A0);
    check("single_wen_early", 32'(b1.mem_wen),   32'd0);
    check("single_busy",      32'(b1.ecg_ready), 32'd0);
    tick();
    check("single_wen",   32'(b1.mem_wen),  32'd1);
    check("single_addr",  32'(b1.mem_addr), 32'h559);
    check("single_data",  b1.mem_wdata,     32'h3A0);
    tick();
    check("single_done",  32'(b1.mem_wen),   32'd0);
    check("single_ready", 32'(b1.ecg_ready), 32'd1);
    check("single_hold",  32'(b1.mem_addr),  32'h559);

    // ---- Both channels in the same cycle: ECG first, then EMG ----
    do_reset();
    b1.ecg_valid = 1'b1;
    b1.ecg_data  = 12'h100;
    b1.emg_valid = 1'b1;
    b1.emg_data  = 12'h200;
    tick();
    b1.ecg_valid = 1'b0;
    b1.emg_valid = 1'b0;
    tick();
    check("both_first_addr",  32'(b1.mem_addr), 32'h559);
    check("both_first_data",  b1.mem_wdata,     32'h100);
    tick();
    check("both_second_addr", 32'(b1.mem_addr), 32'h6AD);
    check("both_second_data", b1.mem_wdata,     32'h200);
    idle(3);

    // ---- Full ECG sweep, amplitude word, wrap to window start ----
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_ecg(12'(10 + i));
    send_ecg(12'd7);
    idle(5);
    check("sweep_count", 32'(log_q.size()), 32'd322);
    if (log_q.size() >= 322) begin
      check("sweep_last_addr",  32'(log_q[319].addr),  32'h698);
      check("sweep_last_data",  log_q[319].data,       32'd329);
      check("sweep_pulse",      32'(log_q[319].sweep), 32'd1);
      check("sweep_stat_addr",  32'(log_q[320].addr),  32'd1704);
      check("sweep_stat_data",  log_q[320].data,       32'd319);
      check("sweep_stat_pulse", 32'(log_q[320].sweep), 32'd0);
      check("sweep_wrap_addr",  32'(log_q[321].addr),  32'h559);
      check("sweep_wrap_data",  log_q[321].data,       32'd7);
    end

    // ---- Freeze: samples accepted and dropped, pointer unchanged ----
    log_q.delete();
    b1.freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("frz_ready", 32'(b1.ecg_ready), 32'd1);
      send_ecg(12'(i + 12'h40));
    end
    idle(3);
    check("frz_no_writes", 32'(log_q.size()), 32'd0);
    b1.freeze = 1'b0;
    send_ecg(12'hABC);
    idle(4);
    check("frz_resume_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) begin
      check("frz_resume_addr", 32'(log_q[0].addr), 32'h55A);
      check("frz_resume_data", log_q[0].data,      32'hABC);
    end

    // ---- Reset in the middle of a write at pointer 57 ----
    do_reset();
    for (int i = 0; i < 57; i++) send_ecg(12'(i));
    idle(3);
    send_ecg(12'h123);
    tick();
    check("midrst_wen",  32'(b1.mem_wen),  32'd1);
    check("midrst_addr", 32'(b1.mem_addr), 32'h592);
    reset = 1'b0;
    #1;
    check("midrst_wen_drop", 32'(b1.mem_wen), 32'd0);
    do_reset();
    send_ecg(12'h456);
    idle(4);
    check("midrst_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) begin
      check("midrst_addr_after", 32'(log_q[0].addr), 32'h559);
      check("midrst_data_after", log_q[0].data,      32'h456);
    end

    // ---- DECIM=4: samples 1..8 back to back give two writes ----
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      b4.ecg_valid = 1'b1;
      b4.ecg_data  = 12'(i);
      done = 1'b0;
      for (int k = 0; k < 16 && !done; k++) begin
        done = b4.ecg_ready;
        tick4();
      end
      check("d4_accept", 32'(done), 32'd1);
    end
    b4.ecg_valid = 1'b0;
    repeat (4) tick4();
`ifdef WAVE_AVG_EN
    exp_a = 32'd2;
    exp_b = 32'd6;
`else
    exp_a = 32'd1;
    exp_b = 32'd5;
`endif
    check("d4_count", 32'(log4_q.size()), 32'd2);
    if (log4_q.size() >= 2) begin
      check("d4_addr0", 32'(log4_q[0].addr), 32'h559);
      check("d4_data0", log4_q[0].data,      exp_a);
      check("d4_addr1", 32'(log4_q[1].addr), 32'h55A);
      check("d4_data1", log4_q[1].data,      exp_b);
    end

    // ---- Randomized traffic on both channels against the model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ((c % 200) == 0) b1.freeze = ($urandom_range(0, 3) == 0);
      b1.ecg_valid = 1'($urandom_range(0, 1));
      b1.ecg_data  = 12'($urandom_range(0, 4095));
      b1.emg_valid = 1'($urandom_range(0, 1));
      b1.emg_data  = 12'($urandom_range(0, 4095));
      tick();
    end
    b1.ecg_valid = 1'b0;
    b1.emg_valid = 1'b0;
    b1.freeze    = 1'b0;
    idle(20);
    check("rand_ecg_drained",  32'(ecg_q.size()),  32'd0);
    check("rand_emg_drained",  32'(emg_q.size()),  32'd0);
    check("rand_stat_drained", 32'(stat_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_waveform_sample_writer
